dac_burst_window_ctrl: RTL
==========================

Name: dac_burst_window_ctrl

Overview:
- Sequences each downlink DAC burst in the clk_50m domain.
- On a slot-start strobe it runs a pre-guard / active / post-guard timeline, drives the DAC write window (dl_data_dac_window) and the modulator sample request, and counts returned msk_data_valid cycles.
- Sits between the slot timer and the MSK modulator / DAC send-out path; exposes busy, done, abort and error status to the control registers.

Parameters:
- LEN_W, 10, width of cfg_burst_len in clk_50m cycles; max 1023 (RAM holds 512 words at half-rate writes).
- GUARD_W, 8, width of the pre/post guard counters.
- CNT_W, 16, width of status counters (optional feature only).

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- sys_rst  in  1  reset; asynchronous, active-high.
- cfg_enable  in  1  controller enable; deassertion aborts any burst.
- cfg_pre_guard  in  GUARD_W  cycles from slot_start to window start.
- cfg_post_guard  in  GUARD_W  cycles after window end before IDLE.
- cfg_burst_len  in  LEN_W  window length in cycles.
- slot_start  in  1  single-cycle burst trigger.
- msk_data_valid  in  1  modulator sample valid.
- err_clr  in  1  clears sticky errors.
- dl_data_dac_window  out  1  DAC write window.
- msk_data_req  out  1  sample request to the modulator.
- burst_busy  out  1  high whenever state is not IDLE.
- burst_done  out  1  one-cycle pulse on normal completion.
- burst_abort  out  1  one-cycle pulse on abort.
- err_overlap  out  1  sticky: slot_start arrived while busy.
- err_underrun  out  1  sticky: valid count < burst length at window end.
- burst_cnt  out  CNT_W  completed bursts (optional feature).
- underrun_cnt  out  CNT_W  underrun events (optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- FSM states: IDLE, PRE_GUARD, ACTIVE, POST_GUARD.

State transitions:
- IDLE: slot_start && cfg_enable latches pre_guard, post_guard and len, clamped to max 1023. Next state:
  - len == 0: burst_done pulses the next cycle, state stays IDLE, no window.
  - pre_guard == 0: ACTIVE.
  - otherwise: PRE_GUARD.
- PRE_GUARD: counts down the latched pre_guard value; goes to ACTIVE on the cycle after the count reaches 1. Exactly pre_guard cycles are spent in the state.
- ACTIVE:
  - dl_data_dac_window = 1 and msk_data_req = 1 for exactly len cycles, registered: both are high on the same cycles the state is ACTIVE.
  - valid_cnt increments on each msk_data_valid cycle while in ACTIVE; it saturates at the all-ones value.
  - On the last ACTIVE cycle: if valid_cnt, including this cycle, is < len, set err_underrun.
  - Then go to POST_GUARD, or to IDLE with a burst_done pulse if post_guard == 0.
- POST_GUARD: counts down post_guard cycles; on exit burst_done pulses for 1 cycle and the state returns to IDLE.

Latency:
- slot_start at cycle T gives window rising at T+1+pre_guard and falling at T+1+pre_guard+len.
- burst_done occurs at T+1+pre_guard+len+post_guard.

Boundary conditions:
- slot_start while not IDLE: ignored; err_overlap is set.
- slot_start on the same cycle as the burst_done pulse: the state is already IDLE, so it is accepted.
- cfg_enable low while not IDLE: next state is IDLE, window and req drop the next cycle, burst_abort pulses, and there is no burst_done and no underrun check.
- cfg_* changes mid-burst: no effect; latched values are used.
- err_clr clears both sticky bits. If err_clr coincides with a new error event, the set wins.
- sys_rst mid-burst: immediately returns to the reset values.

Optional Feature:
- Macro: DAC_BURST_STATUS_CNT_EN.
- Defined:
  - burst_cnt increments on each burst_done; it wraps.
  - underrun_cnt increments on each underrun event; it saturates.
  - Both are cleared only by sys_rst.
- Undefined: burst_cnt and underrun_cnt are tied to 0 and no counter registers are built.

Decomposition:
- Shared package dac_ctrl_pkg:
  - FSM state encoding (2-bit localparams ST_IDLE=0, ST_PRE=1, ST_ACT=2, ST_POST=3).
  - LEN_MAX=1023.
  - Default guard constants.
- One sub-module, dac_guard_timer: a loadable down-counter with load/zero-flag, instantiated twice (pre and post guard). The ACTIVE length counter stays inline.

Test Plan:
1. pre=4, post=3, len=8, msk_data_valid held high, slot_start at T → window high on T+5..T+12; burst_done at T+16; no errors.
2. pre=0, post=0, len=1 → window high on T+1 only; burst_done at T+2; busy high exactly 1 cycle.
3. len=10, valid high for only 7 ACTIVE cycles → err_underrun=1 after the window ends; it stays set until err_clr, then reads 0.
4. slot_start again 2 cycles into ACTIVE → err_overlap=1; timeline unchanged; the second trigger produces no burst.
5. cfg_enable dropped during PRE_GUARD (pre=20) → burst_abort pulse next cycle; window never asserts; no burst_done; burst_busy=0.
6. With DAC_BURST_STATUS_CNT_EN: 3 good bursts plus 1 underrun burst → burst_cnt=4, underrun_cnt=1. Without the macro, both read 0.

Source files
------------

// File: rtl/dac_burst_window_ctrl_pkg.sv
// Shared definitions for the DAC burst window controller: FSM encoding,
// burst length cap, default guard values and the length clamp helper.
package dac_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_ACT  = 2'd2;
    localparam logic [1:0] ST_POST = 2'd3;

    // The sample RAM holds 512 words written at half rate.
    localparam int unsigned LEN_MAX = 1023;

    localparam int unsigned DEF_PRE_GUARD  = 4;
    localparam int unsigned DEF_POST_GUARD = 3;

    function automatic int unsigned clamp_len(input int unsigned len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage

// File: rtl/dac_burst_window_ctrl_if.sv
// Configuration, strobe and status bundle between the slot timer / register
// block (master) and the DAC burst window controller (slave).
interface dac_burst_window_ctrl_if #(
    parameter int LEN_W   = 10,
    parameter int GUARD_W = 8,
    parameter int CNT_W   = 16
);

    logic               cfg_enable;
    logic [GUARD_W-1:0] cfg_pre_guard;
    logic [GUARD_W-1:0] cfg_post_guard;
    logic [LEN_W-1:0]   cfg_burst_len;
    logic               slot_start;
    logic               msk_data_valid;
    logic               err_clr;

    logic               dl_data_dac_window;
    logic               msk_data_req;
    logic               burst_busy;
    logic               burst_done;
    logic               burst_abort;
    logic               err_overlap;
    logic               err_underrun;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   underrun_cnt;

    modport master (
        output cfg_enable, cfg_pre_guard, cfg_post_guard, cfg_burst_len,
        output slot_start, msk_data_valid, err_clr,
        input  dl_data_dac_window, msk_data_req, burst_busy, burst_done,
        input  burst_abort, err_overlap, err_underrun, burst_cnt, underrun_cnt
    );

    modport slave (
        input  cfg_enable, cfg_pre_guard, cfg_post_guard, cfg_burst_len,
        input  slot_start, msk_data_valid, err_clr,
        output dl_data_dac_window, msk_data_req, burst_busy, burst_done,
        output burst_abort, err_overlap, err_underrun, burst_cnt, underrun_cnt
    );

endinterface

// File: rtl/dac_burst_window_ctrl_guard_timer.sv
// Loadable guard down-counter: load wins over decrement, decrement stops at
// zero; flags report an empty count and the final counted cycle.
module dac_guard_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == W'(1));

endmodule

// File: rtl/dac_burst_window_ctrl.sv
// DAC burst sequencer: pre-guard / active window / post-guard per slot_start.
// Optional status counters are built only with DAC_BURST_STATUS_CNT_EN defined.
module dac_burst_window_ctrl
    import dac_ctrl_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int GUARD_W = 8,
    parameter int CNT_W   = 16
) (
    input logic                   clk_50m,
    input logic                   sys_rst,
    dac_burst_window_ctrl_if.slave bus
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] act_rem;
    logic [LEN_W-1:0] valid_cnt;
    logic [LEN_W-1:0] valid_total;
    logic             valid_inc;
    logic             accept;
    logic             abort;
    logic             act_last;
    logic             done_set;
    logic             underrun_set;
    logic             overlap_set;
    logic             pre_zero;
    logic             pre_last;
    logic             post_zero;
    logic             post_last;
    logic             window_q;
    logic             done_q;
    logic             abort_q;
    logic             err_overlap_q;
    logic             err_underrun_q;

    assign len_clamped  = LEN_W'(clamp_len(32'(bus.cfg_burst_len)));
    assign accept       = (state == ST_IDLE) && bus.slot_start && bus.cfg_enable;
    assign abort        = (state != ST_IDLE) && !bus.cfg_enable;
    assign overlap_set  = (state != ST_IDLE) && bus.slot_start;
    assign act_last     = (state == ST_ACT) && (act_rem == LEN_W'(1));

    // The final window cycle's valid counts toward the underrun decision.
    assign valid_inc    = bus.msk_data_valid && (valid_cnt != '1);
    assign valid_total  = valid_cnt + LEN_W'(valid_inc);
    assign underrun_set = act_last && !abort && (valid_total < len_q);

    // Both timers latch their guard at slot acceptance; post holds until POST.
    dac_guard_timer #(.W(GUARD_W)) u_pre_timer (
        .clk      (clk_50m),
        .rst      (sys_rst),
        .load     (accept),
        .load_val (bus.cfg_pre_guard),
        .en       (state == ST_PRE),
        .zero     (pre_zero),
        .last     (pre_last)
    );

    dac_guard_timer #(.W(GUARD_W)) u_post_timer (
        .clk      (clk_50m),
        .rst      (sys_rst),
        .load     (accept),
        .load_val (bus.cfg_post_guard),
        .en       (state == ST_POST),
        .zero     (post_zero),
        .last     (post_last)
    );

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (len_clamped == '0) begin
                        done_set = 1'b1;
                    end else if (bus.cfg_pre_guard == '0) begin
                        state_nxt = ST_ACT;
                    end else begin
                        state_nxt = ST_PRE;
                    end
                end
            end
            ST_PRE: begin
                if (pre_last || pre_zero) begin
                    state_nxt = ST_ACT;
                end
            end
            ST_ACT: begin
                if (act_last) begin
                    if (post_zero) begin
                        state_nxt = ST_IDLE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (post_last) begin
                    state_nxt = ST_IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            done_set  = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or posedge sys_rst) begin
        if (sys_rst) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            act_rem        <= '0;
            valid_cnt      <= '0;
            window_q       <= 1'b0;
            done_q         <= 1'b0;
            abort_q        <= 1'b0;
            err_overlap_q  <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            window_q <= (state_nxt == ST_ACT);
            done_q   <= done_set;
            abort_q  <= abort;
            if (accept) begin
                len_q     <= len_clamped;
                act_rem   <= len_clamped;
                valid_cnt <= '0;
            end else if (state == ST_ACT) begin
                act_rem <= act_rem - LEN_W'(1);
                if (valid_inc) begin
                    valid_cnt <= valid_total;
                end
            end
            // A new error event in the same cycle as err_clr keeps the bit set.
            err_overlap_q  <= overlap_set  | (err_overlap_q  & ~bus.err_clr);
            err_underrun_q <= underrun_set | (err_underrun_q & ~bus.err_clr);
        end
    end

    assign bus.dl_data_dac_window = window_q;
    assign bus.msk_data_req       = window_q;
    assign bus.burst_busy         = (state != ST_IDLE);
    assign bus.burst_done         = done_q;
    assign bus.burst_abort        = abort_q;
    assign bus.err_overlap        = err_overlap_q;
    assign bus.err_underrun       = err_underrun_q;

`ifdef DAC_BURST_STATUS_CNT_EN
    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] underrun_cnt_q;

    // burst_cnt wraps; underrun_cnt saturates. Only sys_rst clears them.
    always_ff @(posedge clk_50m or posedge sys_rst) begin
        if (sys_rst) begin
            burst_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else begin
            if (done_set) begin
                burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            end
            if (underrun_set && (underrun_cnt_q != '1)) begin
                underrun_cnt_q <= underrun_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.burst_cnt    = burst_cnt_q;
    assign bus.underrun_cnt = underrun_cnt_q;
`else
    assign bus.burst_cnt    = {CNT_W{1'b0}};
    assign bus.underrun_cnt = {CNT_W{1'b0}};
`endif

endmodule
